data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single-port 512x32 data memory between NUM_REQ requesters, e.g. the CPU load/store stage (port 0) and the debug/loader port (port 1).
- Issues at most one memory access per cycle using round-robin priority.
- Supports an atomic lock for read-modify-write sequences.
- Tracks the one-cycle read latency of the memory and routes each response back to the requester that issued it.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- DATA_WIDTH, 32, memory word width
- ADDR_WIDTH, 9, word address width (512 words)

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester access request
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_lock  in  NUM_REQ  hold grant after this access (RMW)
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed word addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- req_ready  out  NUM_REQ  one-hot grant; access accepted when valid&ready
- rsp_valid  out  NUM_REQ  one-hot completion strobe
- rsp_rdata  out  DATA_WIDTH  read data, qualified by rsp_valid
- mem_addr  out  ADDR_WIDTH  to memory address
- mem_we  out  1  memory write enable
- mem_wd  out  DATA_WIDTH  memory write data
- mem_rd  in  DATA_WIDTH  memory read data, valid one cycle after address

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE, rr_ptr=0, owner=0.
  - req_ready=0, rsp_valid=0, mem_we=0, mem_addr=0, mem_wd=0, rsp_rdata=0.
  - Any in-flight response is dropped; no rsp_valid after reset.
- req_ready is combinational from req_valid, state and rr_ptr.
  - At most one bit is set.
  - It is never set for a requester whose req_valid=0.
- Arbitration, state IDLE:
  - Grant the first requester with req_valid=1, searching from rr_ptr upward with wrap-around modulo NUM_REQ.
  - On accept, rr_ptr <= granted index+1, wrapping NUM_REQ-1 to 0.
- Memory drive: mem_addr, mem_we and mem_wd are combinational from the granted requester.
  - mem_we = req_we & accept.
  - With no accept, mem_we=0 and mem_addr holds its last value.
- Response pipeline: one register stage.
  - Cycle N: accept.
  - Cycle N+1: rsp_valid[grant]=1, rsp_rdata=mem_rd.
  - Writes also get a rsp_valid strobe at N+1; rsp_rdata is then the old memory word (read-during-write returns old data).
  - Back-to-back accepts give a fully pipelined response every cycle.
- State machine: IDLE, LOCKED.
  - IDLE -> LOCKED: accept with req_lock=1; owner <= granted index.
  - LOCKED: only owner may get req_ready; all other requesters stall.
  - LOCKED -> IDLE: owner accept with req_lock=0, or owner req_valid=0 for 1 cycle (lock released).
  - rr_ptr advances only on the transition back to IDLE, to owner+1.
- Simultaneous requests: only one is granted per cycle. Losers keep valid asserted and must hold addr/wdata stable until accepted.
- Starvation bound: without locks, any valid requester is granted within NUM_REQ cycles.
- Reset mid-lock returns to IDLE immediately.

Decomposition:
- Shared package cpu_pkg: DATA_WIDTH, ADDR_WIDTH, and state encoding localparams ARB_IDLE=1'b0 and ARB_LOCKED=1'b1.
- One sub-module: rr_pick.
  - Combinational round-robin priority picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant and its index.
  - Reused later by the register-file port scheduler.

Test Plan:
- Reset then idle:
  - Stimulus: hold reset 3 cycles, all req_valid=0.
  - Response: all outputs 0; mem_we never 1.
- Single read:
  - Stimulus: preload mem[5]=32'hDEADBEEF; port0 read addr 5.
  - Response: req_ready[0]=1 same cycle; next cycle rsp_valid=2'b01, rsp_rdata=32'hDEADBEEF.
- Contention:
  - Stimulus: both ports continuously valid for 6 cycles from reset.
  - Response: grants alternate 01,10,01,10,01,10; responses follow one cycle later in the same order.
- Write then read:
  - Stimulus: port1 writes 32'h12345678 to addr 511 (wrap-edge address), port1 then reads 511.
  - Response: write strobe ack, then rsp_rdata=32'h12345678.
- Lock:
  - Stimulus: port0 reads addr 7 with lock=1 then writes addr 7 with lock=0, while port1 is continuously valid.
  - Response: port1 req_ready=0 during both port0 accesses; port1 granted the cycle after unlock.
- Reset mid-operation:
  - Stimulus: assert reset in the cycle after a port1 read accept.
  - Response: no rsp_valid emitted; state returns to IDLE; first grant after reset goes to port0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and arbiter state encoding for the data memory path
package cpu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 9;

    localparam logic ARB_IDLE   = 1'b0;
    localparam logic ARB_LOCKED = 1'b1;

    typedef enum logic {
        IDLE   = ARB_IDLE,
        LOCKED = ARB_LOCKED
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request at or after ptr, wrapping
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    // Outer loop is the search distance from ptr; inner loop finds the slot at that distance.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req[j] && ((int'(ptr) + i == j) || (int'(ptr) + i == j + N))) begin
                    found    = 1'b1;
                    grant[j] = 1'b1;
                    idx      = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin arbiter with RMW lock for the shared single-port data memory
module data_mem_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic                          mem_we,
    output logic [DATA_WIDTH-1:0]         mem_wd,
    input  logic [DATA_WIDTH-1:0]         mem_rd
);
    import cpu_pkg::*;

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

    arb_state_t            state;
    logic [IW-1:0]         rr_ptr;
    logic [IW-1:0]         owner;
    logic [IW-1:0]         grant_idx;
    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    rsp_q;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [DATA_WIDTH-1:0] last_wd;
    logic                  any_grant;
    logic                  accept;

    function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
        return (i == LAST) ? '0 : i + 1'b1;
    endfunction

    // While locked only the owner is visible to the picker, so the pointer value is irrelevant.
    always_comb begin
        eligible = req_valid;
        if (state == LOCKED) begin
            eligible = req_valid & (NUM_REQ'(1) << owner);
        end
    end

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .found (any_grant)
    );

    assign accept    = any_grant & ~reset;
    assign req_ready = accept ? grant : '0;
    assign mem_we    = accept & req_we[grant_idx];
    assign mem_addr  = accept ? req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH] : last_addr;
    assign mem_wd    = accept ? req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH] : last_wd;

    // A response already in flight when reset hits is suppressed in that same cycle.
    assign rsp_valid = reset ? '0 : rsp_q;
    assign rsp_rdata = (|rsp_valid) ? mem_rd : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            rsp_q     <= '0;
            last_addr <= '0;
            last_wd   <= '0;
        end else begin
            rsp_q <= req_ready;
            if (accept) begin
                last_addr <= mem_addr;
                last_wd   <= mem_wd;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_lock[grant_idx]) begin
                            state <= LOCKED;
                            owner <= grant_idx;
                        end else begin
                            rr_ptr <= inc(grant_idx);
                        end
                    end
                end
                LOCKED: begin
                    if (!req_valid[owner] || (accept && !req_lock[owner])) begin
                        state  <= IDLE;
                        rr_ptr <= inc(owner);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter with a 512x32 memory model
module tb_data_mem_arbiter;
    localparam int NR = 2;
    localparam int DW = 32;
    localparam int AW = 9;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid, req_we, req_lock, req_ready, rsp_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [DW-1:0]     rsp_rdata, mem_wd, mem_rd;
    logic [AW-1:0]     mem_addr;
    logic              mem_we;
    logic [DW-1:0]     mem [512];

    typedef struct {
        int          due;
        logic [1:0]  port;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    data_mem_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input int a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    // Memory model: registered read, read-during-write returns the old word.
    initial begin
        for (int i = 0; i < 512; i++) mem[i] <= pat(i);
        mem[5] <= 32'hDEAD_BEEF;
        mem_rd <= '0;
        forever begin
            @(posedge clk);
            if (mem_we) mem[mem_addr] <= mem_wd;
            mem_rd <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        req_valid = '0;
        req_we    = '0;
        req_lock  = '0;
    endtask

    task automatic set_req(input int p, input logic we, input logic lk, input int addr, input logic [31:0] wd);
        req_valid[p]          = 1'b1;
        req_we[p]             = we;
        req_lock[p]           = lk;
        req_addr[p*AW +: AW]  = AW'(addr);
        req_wdata[p*DW +: DW] = wd;
    endtask

    task automatic expect_rsp(input int p, input logic [31:0] d);
        exp_t e;
        e.due  = cyc + 1;
        e.port = 2'(1 << p);
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic settle_ready(input string tag, input logic [1:0] exp);
        #1;
        check(tag, 32'(req_ready), 32'(exp));
    endtask

    always @(negedge clk) begin
        exp_t it;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            it = sb.pop_front();
            check("rsp_valid", 32'(rsp_valid), 32'(it.port));
            check("rsp_rdata", rsp_rdata, it.data);
        end else begin
            check("rsp_idle", 32'(rsp_valid), 32'd0);
        end
    end

    initial begin
        logic [1:0] e;
        reset     = 1'b1;
        req_addr  = '0;
        req_wdata = '0;
        idle_all();

        repeat (3) begin
            tick();
            check("rst_ready", 32'(req_ready), 32'd0);
            check("rst_mem_we", 32'(mem_we), 32'd0);
            check("rst_mem_addr", 32'(mem_addr), 32'd0);
            check("rst_mem_wd", mem_wd, 32'd0);
            check("rst_rdata", rsp_rdata, 32'd0);
        end
        reset = 1'b0;

        set_req(0, 1'b0, 1'b0, 5, 32'd0);
        settle_ready("rd_ready", 2'b01);
        check("rd_mem_addr", 32'(mem_addr), 32'd5);
        expect_rsp(0, 32'hDEAD_BEEF);
        tick();
        idle_all();
        tick();

        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(0, 1'b0, 1'b0, 10, 32'd0);
        set_req(1, 1'b0, 1'b0, 20, 32'd0);
        for (int k = 0; k < 6; k++) begin
            e = (k % 2 == 0) ? 2'b01 : 2'b10;
            settle_ready("cont_ready", e);
            expect_rsp(k % 2, pat((k % 2 == 0) ? 10 : 20));
            tick();
        end
        idle_all();
        tick();

        set_req(1, 1'b1, 1'b0, 511, 32'h1234_5678);
        settle_ready("wr_ready", 2'b10);
        check("wr_mem_we", 32'(mem_we), 32'd1);
        check("wr_mem_addr", 32'(mem_addr), 32'd511);
        check("wr_mem_wd", mem_wd, 32'h1234_5678);
        expect_rsp(1, pat(511));
        tick();
        set_req(1, 1'b0, 1'b0, 511, 32'd0);
        settle_ready("rd511_ready", 2'b10);
        check("rd511_mem_we", 32'(mem_we), 32'd0);
        expect_rsp(1, 32'h1234_5678);
        tick();
        idle_all();
        tick();
        check("idle_mem_addr_hold", 32'(mem_addr), 32'd511);

        set_req(0, 1'b0, 1'b1, 7, 32'd0);
        set_req(1, 1'b0, 1'b0, 30, 32'd0);
        settle_ready("lock_rd_ready", 2'b01);
        expect_rsp(0, pat(7));
        tick();
        set_req(0, 1'b1, 1'b0, 7, 32'h0BAD_F00D);
        settle_ready("lock_wr_ready", 2'b01);
        expect_rsp(0, pat(7));
        tick();
        req_valid[0] = 1'b0;
        settle_ready("unlock_ready", 2'b10);
        expect_rsp(1, pat(30));
        tick();
        idle_all();
        tick();

        set_req(1, 1'b0, 1'b1, 40, 32'd0);
        settle_ready("lock1_ready", 2'b10);
        expect_rsp(1, pat(40));
        tick();
        req_valid[1] = 1'b0;
        set_req(0, 1'b0, 1'b0, 7, 32'd0);
        settle_ready("drop_ready", 2'b00);
        tick();
        settle_ready("after_drop_ready", 2'b01);
        expect_rsp(0, 32'h0BAD_F00D);
        tick();
        idle_all();
        tick();

        set_req(1, 1'b0, 1'b1, 50, 32'd0);
        settle_ready("pre_rst_ready", 2'b10);
        tick();
        reset = 1'b1;
        idle_all();
        #1;
        check("rst_drop_rsp", 32'(rsp_valid), 32'd0);
        tick();
        reset = 1'b0;
        set_req(0, 1'b0, 1'b0, 60, 32'd0);
        set_req(1, 1'b0, 1'b0, 61, 32'd0);
        settle_ready("post_rst_ready", 2'b01);
        expect_rsp(0, pat(60));
        tick();
        idle_all();
        repeat (3) tick();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
